pc_stack_ctrl: RTL and testbench
================================

Name: pc_stack_ctrl

Overview:
- Program-counter and return-address-stack controller for the PBL core.
- Consumes the flow-control strobes produced by the instruction decoder (jmp, cal, ret, push, pop, jmp_addr) and generates the next instruction address each cycle.
- Holds a LIFO of return addresses for CALL/RET.
- Detects stack overflow, stack underflow and inconsistent strobe combinations, and halts the PC on any of them.

Parameters:
- PC_WIDTH, 5, width of the PC and of jmp_addr.
- STACK_DEPTH, 8, number of return-address entries; must be a power of two, 2..64.
- SP_WIDTH, 3, log2(STACK_DEPTH); width of the stack pointer index.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- en  input  1  advance enable; when 0 all state holds.
- jmp  input  1  jump strobe from the decoder.
- cal  input  1  call strobe from the decoder.
- ret  input  1  return strobe from the decoder.
- push  input  1  stack-push strobe from the decoder.
- pop  input  1  stack-pop strobe from the decoder.
- jmp_addr  input  PC_WIDTH  jump/call target.
- pc  output  PC_WIDTH  current instruction address (registered).
- sp  output  SP_WIDTH+1  number of valid stack entries, 0..STACK_DEPTH.
- stack_full  output  1  sp == STACK_DEPTH (combinational from sp).
- stack_empty  output  1  sp == 0 (combinational from sp).
- overflow  output  1  sticky: CALL attempted with a full stack.
- underflow  output  1  sticky: RET attempted with an empty stack.
- protocol_err  output  1  sticky: inconsistent strobe set.
- halted  output  1  OR of overflow, underflow and protocol_err.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=0, sp=0, overflow=0, underflow=0, protocol_err=0, halted=0.
  - Stack RAM contents are not reset.
- All updates occur on the rising clk edge, only when en=1 and halted=0. Otherwise every register holds.
- Legal strobe sets, as {push,pop,jmp,cal,ret}:
  - 00000: sequential.
  - 00100: jump.
  - 10110: call.
  - 01001: return.
- Any other set with en=1 and halted=0 sets protocol_err. pc and sp hold that cycle.
- Sequential: pc <= pc+1, wrapping modulo 2^PC_WIDTH (31 -> 0 at default).
- Jump: pc <= jmp_addr.
- Call:
  - If sp < STACK_DEPTH: stack[sp] <= pc+1 (mod 2^PC_WIDTH), sp <= sp+1, pc <= jmp_addr.
  - If sp == STACK_DEPTH: overflow <= 1; pc, sp and stack unchanged.
- Return:
  - If sp > 0: pc <= stack[sp-1], sp <= sp-1.
  - If sp == 0: underflow <= 1; pc and sp unchanged.
- Latency: the new pc is visible the cycle after the strobe edge. The stack read is from registered sp, so a call followed directly by a return yields the pushed address.
- halted is combinational from the sticky flags.
  - Once set, pc, sp and the flags freeze until reset.
  - Only rst_n clears the flags.
- Strobe sampling: jmp/cal/ret/push/pop are sampled only on enabled edges. Glitches with en=0 are ignored, and no error is flagged while en=0.
- Reset mid-call/return: asynchronous reset wins immediately; no partial push or pop is retained (sp=0).
- State machine: two states, RUN and HALT.
  - RUN -> HALT on any error-flag set.
  - HALT -> RUN only via reset.
- Stack storage: register array of STACK_DEPTH x PC_WIDTH; one write port, one read port.

Test Plan:
- Reset, then 33 enabled sequential cycles -> pc steps 0..31 then wraps to 0, then 1; sp=0, stack_empty=1.
- At pc=3, jump (00100, jmp_addr=20) -> next pc=20. Repeat with en=0 -> pc stays 3.
- At pc=3, call to 10 (10110) -> pc=10, sp=1. Call again from pc=12 to 25 -> pc=25, sp=2. Return -> pc=13, sp=1. Return -> pc=4, sp=0, stack_empty=1.
- Eight calls -> sp=8, stack_full=1. Ninth call -> overflow=1, halted=1, pc unchanged. Further enabled cycles -> pc frozen. Reset -> all flags 0, pc=0.
- Return with sp=0 -> underflow=1, halted=1, pc holds. Separately, strobes 00010 (cal without push/jmp) -> protocol_err=1, halted=1.
- Call from pc=5 to 18, then assert rst_n=0 mid-cycle before the next edge -> pc=0 and sp=0 immediately. After release, sequential counting resumes from 0.

Source files
------------

// File: rtl/pc_stack_ctrl.sv
// Program-counter and return-address-stack controller.
// Turns decoder flow-control strobes into the next instruction address,
// keeps a LIFO of return addresses for CALL/RET, and halts on any error.
module pc_stack_ctrl #(
    parameter int PC_WIDTH    = 5,
    parameter int STACK_DEPTH = 8,
    parameter int SP_WIDTH    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                jmp,
    input  logic                cal,
    input  logic                ret,
    input  logic                push,
    input  logic                pop,
    input  logic [PC_WIDTH-1:0] jmp_addr,
    output logic [PC_WIDTH-1:0] pc,
    output logic [SP_WIDTH:0]   sp,
    output logic                stack_full,
    output logic                stack_empty,
    output logic                overflow,
    output logic                underflow,
    output logic                protocol_err,
    output logic                halted
);

    // Legal strobe sets, packed as {push, pop, jmp, cal, ret}.
    localparam logic [4:0] STB_SEQ  = 5'b00000;
    localparam logic [4:0] STB_JUMP = 5'b00100;
    localparam logic [4:0] STB_CALL = 5'b10110;
    localparam logic [4:0] STB_RET  = 5'b01001;

    localparam logic [SP_WIDTH:0]   SP_FULL = (SP_WIDTH+1)'(STACK_DEPTH);
    localparam logic [SP_WIDTH:0]   SP_ZERO = '0;
    localparam logic [SP_WIDTH:0]   SP_ONE  = (SP_WIDTH+1)'(1);
    localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [SP_WIDTH:0]     sp_q, sp_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  protocol_err_q, protocol_err_d;

    logic [PC_WIDTH-1:0]   stack_q [STACK_DEPTH];
    logic                  stack_we;
    logic [SP_WIDTH-1:0]   stack_waddr;
    logic [SP_WIDTH-1:0]   stack_raddr;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [4:0]            strobes;

    assign strobes     = {push, pop, jmp, cal, ret};
    assign pc_inc      = pc_q + PC_ONE;
    // Top of stack lives at sp-1; the push slot is sp itself.
    assign stack_waddr = sp_q[SP_WIDTH-1:0];
    assign stack_raddr = SP_WIDTH'(sp_q - SP_ONE);

    // Next-state decode: strobes act only on enabled edges while running.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d        = state_q;
        pc_d           = pc_q;
        sp_d           = sp_q;
        overflow_d     = overflow_q;
        underflow_d    = underflow_q;
        protocol_err_d = protocol_err_q;
        stack_we       = 1'b0;

        if (en && (state_q == ST_RUN)) begin
            case (strobes)
                STB_SEQ:  pc_d = pc_inc;
                STB_JUMP: pc_d = jmp_addr;
                STB_CALL: begin
                    if (sp_q == SP_FULL) begin
                        overflow_d = 1'b1;
                    end else begin
                        stack_we = 1'b1;
                        sp_d     = sp_q + SP_ONE;
                        pc_d     = jmp_addr;
                    end
                end
                STB_RET: begin
                    if (sp_q == SP_ZERO) begin
                        underflow_d = 1'b1;
                    end else begin
                        sp_d = sp_q - SP_ONE;
                        pc_d = stack_q[stack_raddr];
                    end
                end
                default:  protocol_err_d = 1'b1;
            endcase
        end

        if (overflow_d || underflow_d || protocol_err_d) begin
            state_d = ST_HALT;
        end
    end

    // Control registers: PC, stack pointer, sticky error flags and run/halt state.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q        <= ST_RUN;
            pc_q           <= '0;
            sp_q           <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            sp_q           <= sp_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    // Return-address storage: single write port, read combinationally above.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; sp tracks which entries are valid.
        if (stack_we) begin
            stack_q[stack_waddr] <= pc_inc;
        end
    end

    assign pc           = pc_q;
    assign sp           = sp_q;
    assign stack_full   = (sp_q == SP_FULL);
    assign stack_empty  = (sp_q == SP_ZERO);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign protocol_err = protocol_err_q;
    assign halted       = overflow_q | underflow_q | protocol_err_q;

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Directed testbench for pc_stack_ctrl with hand-computed expectations.
module tb_pc_stack_ctrl;

    localparam logic [4:0] S_SEQ  = 5'b00000;
    localparam logic [4:0] S_JUMP = 5'b00100;
    localparam logic [4:0] S_CALL = 5'b10110;
    localparam logic [4:0] S_RET  = 5'b01001;
    localparam logic [4:0] S_BAD  = 5'b00010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       jmp = 1'b0, cal = 1'b0, ret = 1'b0, push = 1'b0, pop = 1'b0;
    logic [4:0] jmp_addr = '0;
    logic [4:0] pc;
    logic [3:0] sp;
    logic       stack_full, stack_empty, overflow, underflow, protocol_err, halted;

    int n_checks = 0;
    int n_errors = 0;

    pc_stack_ctrl #(.PC_WIDTH(5), .STACK_DEPTH(8), .SP_WIDTH(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .jmp          (jmp),
        .cal          (cal),
        .ret          (ret),
        .push         (push),
        .pop          (pop),
        .jmp_addr     (jmp_addr),
        .pc           (pc),
        .sp           (sp),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .protocol_err (protocol_err),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one strobe set for one edge, then sample 1 time unit after it.
    task automatic step(input logic [4:0] s, input logic [4:0] a, input logic e);
        {push, pop, jmp, cal, ret} = s;
        jmp_addr = a;
        en       = e;
        @(posedge clk);
        #1;
        {push, pop, jmp, cal, ret} = '0;
        en = 1'b0;
    endtask

    // Pulse reset mid-cycle, away from any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic check_flags(input string tag, input int ovf, input int unf, input int perr);
        check({tag, " overflow"}, int'(overflow), ovf);
        check({tag, " underflow"}, int'(underflow), unf);
        check({tag, " protocol_err"}, int'(protocol_err), perr);
        check({tag, " halted"}, int'(halted), int'((ovf | unf | perr) != 0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        #3;
        check("rst pc", int'(pc), 0);
        check("rst sp", int'(sp), 0);
        check("rst empty", int'(stack_empty), 1);
        check("rst full", int'(stack_full), 0);
        check_flags("rst", 0, 0, 0);
        rst_n = 1'b1;

        // 33 sequential cycles: 1..31, wrap to 0, then 1.
        for (int i = 0; i < 33; i++) begin
            step(S_SEQ, 5'd0, 1'b1);
            check("seq pc", int'(pc), (i + 1) % 32);
        end
        check("seq sp", int'(sp), 0);
        check("seq empty", int'(stack_empty), 1);

        // Advance to pc=3, then a jump with en=0 must be ignored.
        step(S_SEQ, 5'd0, 1'b1);
        step(S_SEQ, 5'd0, 1'b1);
        check("pre-jump pc", int'(pc), 3);
        step(S_JUMP, 5'd20, 1'b0);
        check("jump en0 pc", int'(pc), 3);
        step(S_BAD, 5'd0, 1'b0);
        check("glitch en0 pc", int'(pc), 3);
        check_flags("glitch en0", 0, 0, 0);
        step(S_JUMP, 5'd20, 1'b1);
        check("jump pc", int'(pc), 20);

        // Nested call/return.
        do_reset();
        for (int i = 0; i < 3; i++) step(S_SEQ, 5'd0, 1'b1);
        check("call0 start pc", int'(pc), 3);
        step(S_CALL, 5'd10, 1'b1);
        check("call1 pc", int'(pc), 10);
        check("call1 sp", int'(sp), 1);
        step(S_SEQ, 5'd0, 1'b1);
        step(S_SEQ, 5'd0, 1'b1);
        step(S_CALL, 5'd25, 1'b1);
        check("call2 pc", int'(pc), 25);
        check("call2 sp", int'(sp), 2);
        step(S_RET, 5'd0, 1'b1);
        check("ret1 pc", int'(pc), 13);
        check("ret1 sp", int'(sp), 1);
        step(S_RET, 5'd0, 1'b1);
        check("ret2 pc", int'(pc), 4);
        check("ret2 sp", int'(sp), 0);
        check("ret2 empty", int'(stack_empty), 1);

        // Fill the stack: calls to 0,2,..,14 from pc=4.
        for (int i = 0; i < 8; i++) begin
            step(S_CALL, 5'(2 * i), 1'b1);
            check("fill sp", int'(sp), i + 1);
        end
        check("fill pc", int'(pc), 14);
        check("fill full", int'(stack_full), 1);
        check("fill empty", int'(stack_empty), 0);
        check_flags("fill", 0, 0, 0);

        // Ninth call overflows and halts.
        step(S_CALL, 5'd30, 1'b1);
        check("ovf pc", int'(pc), 14);
        check("ovf sp", int'(sp), 8);
        check_flags("ovf", 1, 0, 0);
        for (int i = 0; i < 3; i++) step(S_SEQ, 5'd0, 1'b1);
        step(S_RET, 5'd0, 1'b1);
        check("frozen pc", int'(pc), 14);
        check("frozen sp", int'(sp), 8);
        check_flags("frozen", 1, 0, 0);

        do_reset();
        check("ovf rst pc", int'(pc), 0);
        check("ovf rst sp", int'(sp), 0);
        check_flags("ovf rst", 0, 0, 0);

        // Return on an empty stack.
        step(S_RET, 5'd0, 1'b1);
        check("unf pc", int'(pc), 0);
        check("unf sp", int'(sp), 0);
        check_flags("unf", 0, 1, 0);
        do_reset();

        // Call strobe without push/jmp is a protocol error.
        step(S_SEQ, 5'd0, 1'b1);
        step(S_BAD, 5'd9, 1'b1);
        check("perr pc", int'(pc), 1);
        check("perr sp", int'(sp), 0);
        check_flags("perr", 0, 0, 1);
        step(S_SEQ, 5'd0, 1'b1);
        check("perr frozen pc", int'(pc), 1);
        do_reset();

        // Reset between a call and the next edge.
        for (int i = 0; i < 5; i++) step(S_SEQ, 5'd0, 1'b1);
        check("midrst start pc", int'(pc), 5);
        step(S_CALL, 5'd18, 1'b1);
        check("midrst call pc", int'(pc), 18);
        check("midrst call sp", int'(sp), 1);
        rst_n = 1'b0;
        #1;
        check("midrst pc", int'(pc), 0);
        check("midrst sp", int'(sp), 0);
        rst_n = 1'b1;
        step(S_SEQ, 5'd0, 1'b1);
        check("resume pc1", int'(pc), 1);
        step(S_SEQ, 5'd0, 1'b1);
        check("resume pc2", int'(pc), 2);
        check("resume sp", int'(sp), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
